alu4_stage: RTL and testbench
=============================

# alu4_stage

Registered 4-bit ALU stage directly downstream of the `nand4` gate. It accepts operand pairs plus an opcode over a valid/ready handshake and computes one of eight operations, reusing `nand4` for the NAND case. The result goes through a two-stage pipeline (operand register, then result register) with full backpressure. This is the first clocked stage of the ALU datapath: it turns the combinational gate library into a streamable unit.

## Interface
Parameters:
- `WIDTH`, default 4: operand/result width. The NAND path instantiates `nand4` only when `WIDTH` == 4; otherwise it uses a generic `~(a & b)`.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, synchronous, active-low.
- `in_valid`  in  1  Upstream presents `a`, `b`, `op`.
- `in_ready`  out  1  Stage can accept this cycle.
- `a`  in  WIDTH  Operand A.
- `b`  in  WIDTH  Operand B.
- `op`  in  3  Opcode (see Operation).
- `out_valid`  out  1  `y` and flags are valid.
- `out_ready`  in  1  Downstream accepts this cycle.
- `y`  out  WIDTH  Result.
- `carry`  out  1  Carry/no-borrow flag (only with `ALU4_FLAGS_EN`).
- `zero`  out  1  High when `y` == 0 (only with `ALU4_FLAGS_EN`).

## Operation
- Opcodes:
  - 000 NAND, 001 AND, 010 OR, 011 XOR: `carry` = 0.
  - 100 ADD: `y` = (a+b) mod 2^WIDTH; `carry` = bit WIDTH of the sum.
  - 101 SUB: `y` = (a−b) mod 2^WIDTH; `carry` = 1 when a ≥ b (no borrow).
  - 110 NOT A: `carry` = 0.
  - 111 PASS B: `carry` = 0.
- Stage 1 (S1): registers `a`, `b`, `op`; holds `s1_valid`.
- Stage 2 (S2): registers `y` and flags computed from S1; holds `s2_valid`, which drives `out_valid`.
- Each stage is EMPTY or FULL:
  - S2 loads when S1 is FULL and (S2 is EMPTY or `out_ready`).
  - S1 loads when `in_valid` && `in_ready`.
  - `in_ready` = !`s1_valid` || S2 loading (combinational).
- Simultaneous load and drain of a stage is legal; the stage stays FULL with the new data.
- Results leave in acceptance order. No reordering, no drop, no duplication.
- While `out_valid` && !`out_ready`: `y` and flags hold stable.
- Reset (rst_n low at an edge): both stages go EMPTY, and in-flight operations are discarded.
  - Reset values: `out_valid` 0, `y` 0, `carry` 0, `zero` 0.
  - `in_valid` is ignored in any cycle where `rst_n` is low.
  - `in_ready` is 1 from the first cycle after reset release.

## Timing
- Latency: an operation accepted at edge N presents `out_valid` = 1 after edge N+1 (visible in cycle N+1→N+2). That is 2 edges from `in_valid`/`in_ready` to the output register update.
- Throughput: one operation per cycle when `out_ready` is held at 1.
- Capacity: 2 operations. With `out_ready` = 0, `in_ready` falls after the second accept.
- There is no combinational path from `a`, `b`, `op` to `y`. The only combinational path is `out_ready` → `in_ready`.

## Configuration
- `ALU4_FLAGS_EN` defined:
  - `carry` and `zero` ports exist.
  - They are registered in S2 alongside `y` and reset to 0.
- `ALU4_FLAGS_EN` undefined:
  - `carry` and `zero` ports and all flag logic are absent.
  - ADD/SUB still produce `y` mod 2^WIDTH.
  - Handshake and latency are unchanged.

## Structure
- Package `alu4_pkg`:
  - opcode constants (`OP_NAND` … `OP_PASSB`, 3-bit);
  - default `WIDTH` constant (4).
- Sub-module `alu4_core`:
  - combinational opcode decode and arithmetic; instantiates `nand4`;
  - outputs raw `y`, `carry`, `zero`.
- `alu4_stage` holds only the two pipeline registers and the handshake logic.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `y` = 0, `carry` = 0, `zero` = 0; `in_ready` = 1 in the first cycle after release; no output appears.
- NAND/logic: a = 4'hA, b = 4'hF, op = 000 → `y` = 4'h5 two edges after accept, `zero` = 0, `carry` = 0; op = 011 with a = b = 4'h6 → `y` = 0, `zero` = 1.
- Arithmetic:
  - ADD 9+8 → `y` = 4'h1, `carry` = 1.
  - SUB 3−5 → `y` = 4'hE, `carry` = 0.
  - SUB 5−5 → `y` = 0, `zero` = 1, `carry` = 1.
- Backpressure: `out_ready` = 0, offer 3 ops → 2 accepted, then `in_ready` = 0 and `y` holds stable; raise `out_ready` → all 3 results emerge in order with no gaps after the first.
- Throughput: `out_ready` = 1, 8 back-to-back ADDs of i+1 for i = 0..7 → 8 consecutive `out_valid` cycles with `y` = 1..8.
- Mid-operation reset: 2 ops in flight, pull `rst_n` low for 1 edge → `out_valid` = 0 at the next edge; neither op is ever emitted.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared constants for the registered 4-bit ALU stage: default width and opcodes.
// Flag outputs (carry/zero) elsewhere are compiled in only with ALU4_FLAGS_EN.
package alu4_pkg;

    localparam int ALU4_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_NAND  = 3'b000,
        OP_AND   = 3'b001,
        OP_OR    = 3'b010,
        OP_XOR   = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSB = 3'b111
    } alu4_op_e;

endpackage

// File: rtl/alu4_if.sv
// Valid/ready request and response bundle for alu4_stage.
// carry/zero exist only when ALU4_FLAGS_EN is defined.
interface alu4_if
    import alu4_pkg::*;
#(
    parameter int WIDTH = ALU4_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
`ifdef ALU4_FLAGS_EN
    logic             carry;
    logic             zero;
`endif

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y
`ifdef ALU4_FLAGS_EN
        , output carry, zero
`endif
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y
`ifdef ALU4_FLAGS_EN
        , input carry, zero
`endif
    );

endinterface

// File: rtl/alu4_core.sv
// Combinational opcode decode and arithmetic for alu4_stage.
// carry/zero outputs and their logic exist only with ALU4_FLAGS_EN.
module alu4_core
    import alu4_pkg::*;
#(
    parameter int WIDTH = ALU4_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
`ifdef ALU4_FLAGS_EN
    ,
    output logic             carry,
    output logic             zero
`endif
);
    logic [WIDTH-1:0] nand_y;

    // The library gate is fixed at 4 bits; other widths fall back to plain logic.
    generate
        if (WIDTH == 4) begin : g_nand4
            nand4 u_nand4 (
                .a (a),
                .b (b),
                .y (nand_y)
            );
        end else begin : g_nand_gen
            assign nand_y = ~(a & b);
        end
    endgenerate

    always_comb begin
        y = '0;
`ifdef ALU4_FLAGS_EN
        carry = 1'b0;
`endif
        case (op)
            OP_NAND:  y = nand_y;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_ADD: begin
`ifdef ALU4_FLAGS_EN
                {carry, y} = {1'b0, a} + {1'b0, b};
`else
                y = a + b;
`endif
            end
            OP_SUB: begin
                y = a - b;
`ifdef ALU4_FLAGS_EN
                carry = (a >= b);
`endif
            end
            OP_NOTA:  y = ~a;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

`ifdef ALU4_FLAGS_EN
    assign zero = (y == '0);
`endif

endmodule

// File: rtl/nand4.sv
// 4-bit bitwise NAND gate from the combinational gate library.
module nand4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = ~(a & b);
endmodule

// File: rtl/alu4_stage.sv
// Two-stage registered ALU (operand register S1, result register S2) with full backpressure.
// Optional carry/zero flags are registered in S2 when ALU4_FLAGS_EN is defined.
module alu4_stage
    import alu4_pkg::*;
#(
    parameter int WIDTH = ALU4_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    alu4_if.slave bus
);
    // vld_pipe[1] = S1 full, vld_pipe[2] = S2 full
    logic [2:1]       vld_pipe;
    logic             s1_valid;
    logic             s2_valid;
    logic             s1_load;
    logic             s2_load;

    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] y_q;
`ifdef ALU4_FLAGS_EN
    logic             core_carry;
    logic             core_zero;
    logic             carry_q;
    logic             zero_q;
`endif

    assign s1_valid = vld_pipe[1];
    assign s2_valid = vld_pipe[2];

    // out_ready -> in_ready is the only combinational path through the stage.
    assign s2_load     = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s2_load;
    assign s1_load     = bus.in_valid && bus.in_ready;

    alu4_core #(.WIDTH(WIDTH)) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .y     (core_y)
`ifdef ALU4_FLAGS_EN
        ,
        .carry (core_carry),
        .zero  (core_zero)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            y_q      <= '0;
`ifdef ALU4_FLAGS_EN
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            vld_pipe[1] <= s1_load || (s1_valid && !s2_load);
            vld_pipe[2] <= s2_load || (s2_valid && !bus.out_ready);
            if (s1_load) begin
                s1_a  <= bus.a;
                s1_b  <= bus.b;
                s1_op <= bus.op;
            end
            if (s2_load) begin
                y_q     <= core_y;
`ifdef ALU4_FLAGS_EN
                carry_q <= core_carry;
                zero_q  <= core_zero;
`endif
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.y         = y_q;
`ifdef ALU4_FLAGS_EN
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_alu4_stage.sv
// Directed self-checking bench for alu4_stage; flag checks compile in with ALU4_FLAGS_EN.
module tb_alu4_stage;
    import alu4_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu4_if #(.WIDTH(4)) bus ();

    alu4_stage #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic ec, input logic ez);
`ifdef ALU4_FLAGS_EN
        chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, ec});
        chk({tag, "_zero"},  {31'd0, bus.zero},  {31'd0, ez});
`else
        if (ec === 1'bx || ez === 1'bx) chk({tag, "_flagarg"}, 32'd0, 32'd1);
`endif
    endtask

    // Single op through an empty pipe with out_ready held high.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic [3:0] ey,
                          input logic ec, input logic ez);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.op        = op;
        #1;
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_early"}, {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_y"}, {28'd0, bus.y}, {28'd0, ey});
        chk_flags(tag, ec, ez);
        tick();
        chk({tag, "_drain"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 4'hF;
        bus.b         = 4'hF;
        bus.op        = OP_ADD;
        bus.out_ready = 1'b1;

        // Reset held 2 edges with in_valid asserted
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_y", {28'd0, bus.y}, 32'd0);
        chk_flags("rst", 1'b0, 1'b0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("rst_quiet0", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("rst_quiet1", {31'd0, bus.out_valid}, 32'd0);

        run_op("nand",  4'hA, 4'hF, OP_NAND,  4'h5, 1'b0, 1'b0);
        run_op("xor",   4'h6, 4'h6, OP_XOR,   4'h0, 1'b0, 1'b1);
        run_op("and",   4'hC, 4'hA, OP_AND,   4'h8, 1'b0, 1'b0);
        run_op("or",    4'hC, 4'hA, OP_OR,    4'hE, 1'b0, 1'b0);
        run_op("add",   4'h9, 4'h8, OP_ADD,   4'h1, 1'b1, 1'b0);
        run_op("sub_b", 4'h3, 4'h5, OP_SUB,   4'hE, 1'b0, 1'b0);
        run_op("sub_z", 4'h5, 4'h5, OP_SUB,   4'h0, 1'b1, 1'b1);
        run_op("nota",  4'h5, 4'h0, OP_NOTA,  4'hA, 1'b0, 1'b0);
        run_op("passb", 4'hF, 4'h3, OP_PASSB, 4'h3, 1'b0, 1'b0);

        // Backpressure: three ADDs 1+1, 2+2, 3+3 offered with out_ready low
        bus.out_ready = 1'b0;
        bus.op        = OP_ADD;
        bus.in_valid  = 1'b1;
        bus.a = 4'h1; bus.b = 4'h1;
        tick();
        bus.a = 4'h2; bus.b = 4'h2;
        #1;
        chk("bp_rdy2", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.a = 4'h3; bus.b = 4'h3;
        #1;
        chk("bp_full", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_y0", {28'd0, bus.y}, 32'h2);
        tick();
        chk("bp_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold_y", {28'd0, bus.y}, 32'h2);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_r2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_r2_y", {28'd0, bus.y}, 32'h4);
        tick();
        chk("bp_r3_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_r3_y", {28'd0, bus.y}, 32'h6);
        tick();
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Throughput: ADD i+1 for i = 0..7 back to back
        bus.out_ready = 1'b1;
        bus.op        = OP_ADD;
        bus.b         = 4'h1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            bus.in_valid = (cyc < 8);
            bus.a        = 4'(cyc);
            #1;
            if (cyc < 8) chk($sformatf("tp_rdy%0d", cyc), {31'd0, bus.in_ready}, 32'd1);
            tick();
            if (cyc >= 1 && cyc <= 8) begin
                chk($sformatf("tp_valid%0d", cyc), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("tp_y%0d", cyc), {28'd0, bus.y}, cyc);
            end else begin
                chk($sformatf("tp_idle%0d", cyc), {31'd0, bus.out_valid}, 32'd0);
            end
        end
        bus.in_valid = 1'b0;

        // Mid-operation reset with two ops in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a = 4'h7; bus.b = 4'h7;
        tick();
        bus.a = 4'h1; bus.b = 4'h2;
        tick();
        bus.in_valid = 1'b0;
        chk("mr_inflight", {31'd0, bus.out_valid}, 32'd1);
        chk("mr_full", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("mr_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mr_y", {28'd0, bus.y}, 32'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mr_quiet%0d", k), {31'd0, bus.out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
